// File: rtl/conv_processor_result_reader_if.sv
// Host/memory-side signal bundle for the result reader.
// master = host + result memory, slave = the reader itself.
interface conv_processor_result_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [ADDR_WIDTH:0]   size;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    output start, size, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, size, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/conv_processor_result_reader.sv
// Streams `size` result-memory words from address 0 to the host through a
// 2-entry output buffer; reads are credit-limited so the buffer never overflows.
module conv_processor_result_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input logic                          clk,
  input logic                          rst,
  conv_processor_result_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   size_q, size_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH:0]   acc_cnt_q, acc_cnt_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q;
  logic                  busy_q, done_q;
  logic                  pop_s, push_s, issue_s, credit_s;

  assign pop_s    = (occ_q != 2'd0) && bus.out_ready;
  assign push_s   = inflight_q;
  // Slots already claimed (held + in flight - leaving now) must stay below 2.
  assign credit_s = (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));

  assign bus.mem_rd_en = issue_s;
  assign bus.mem_addr  = rd_cnt_q[ADDR_WIDTH-1:0];
  assign bus.out_data  = buf_q[rd_ptr_q];
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    rd_cnt_d  = rd_cnt_q;
    acc_cnt_d = pop_s ? (acc_cnt_q + CNT_ONE) : acc_cnt_q;
    issue_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          size_d    = bus.size;
          rd_cnt_d  = CNT_ZERO;
          acc_cnt_d = CNT_ZERO;
          state_d   = (bus.size == CNT_ZERO) ? S_FINISH : S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        issue_s = credit_s;
        if (credit_s) begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
          state_d  = ((rd_cnt_q + CNT_ONE) == size_q) ? S_DRAIN : S_READ;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (pop_s && ((acc_cnt_q + CNT_ONE) == size_q)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= CNT_ZERO;
      rd_cnt_q  <= CNT_ZERO;
      acc_cnt_q <= CNT_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      rd_cnt_q  <= rd_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      busy_q    <= (state_d == S_READ) || (state_d == S_DRAIN);
      done_q    <= (state_d == S_FINISH);
    end
  end

  // Output buffer: read data lands one cycle after its strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight_q <= issue_s;
      if (push_s) begin
        buf_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_processor_result_reader.sv
// Scoreboard bench for conv_processor_result_reader: expected words are queued
// at start and popped on every observed handshake.
module tb_conv_processor_result_reader;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_processor_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_processor_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [64];
  logic [DW-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int exp_addr = 0;
  int rd_issued = 0;
  int acc = 0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronous one-cycle-latency result memory.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Monitor: reads, handshakes, hold-while-stalled and outstanding bound.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en) begin
        check_eq("addr", {26'd0, bus.mem_addr}, exp_addr);
        exp_addr++;
        rd_issued++;
      end
      if (stall_prev && bus.out_valid) check_eq("hold", {16'd0, bus.out_data}, {16'd0, held});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check_eq("extra_word", {16'd0, bus.out_data}, 32'hFFFF_FFFF);
        else check_eq("data", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
        acc++;
      end
      if (bus.busy) check_eq("outstanding_le2", ((rd_issued - acc) <= 2), 32'd1);
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic ready_pat(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Launch a transfer at edge E and wait (bounded) for done; exp_done < 0 skips timing check.
  task automatic run_xfer(input int n, input int mode, input int exp_done, input int glitch);
    int cyc;
    logic got_done;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.size      = 7'(n);
    bus.out_ready = ready_pat(mode, 0);
    @(posedge clk);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    exp_addr  = 0;
    rd_issued = 0;
    acc       = 0;
    #1 bus.start = 1'b0;
    cyc = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        bus.out_ready = ready_pat(mode, cyc);
        bus.start     = (cyc == glitch);
        if (cyc == glitch) bus.size = 7'd2;
      end
    end
    check_eq("done_seen", got_done, 32'd1);
    if (exp_done >= 0) check_eq("done_cycle", cyc, exp_done);
    check_eq("busy_at_done", bus.busy, 32'd0);
    check_eq("words_left", exp_q.size(), 32'd0);
    check_eq("accepted", acc, n);
    check_eq("reads", rd_issued, n);
    @(negedge clk);
    check_eq("done_pulse", bus.done, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rd_en"},  bus.mem_rd_en, 32'd0);
    check_eq({tag, "_addr"},   {26'd0, bus.mem_addr}, 32'd0);
    check_eq({tag, "_valid"},  bus.out_valid, 32'd0);
    check_eq({tag, "_busy"},   bus.busy, 32'd0);
    check_eq({tag, "_done"},   bus.done, 32'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    bus.start     = 1'b0;
    bus.size      = 7'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_eq("reset_data", {16'd0, bus.out_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("idle");

    run_xfer(0, 0, 1, -1);
    run_xfer(4, 0, 7, -1);
    run_xfer(5, 1, -1, -1);
    run_xfer(64, 0, 67, -1);
    run_xfer(6, 0, 9, 3);

    // Reset in the middle of an 8-word transfer after 3 words accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.size  = 7'd8;
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
    exp_addr = 0; rd_issued = 0; acc = 0;
    #1 bus.start = 1'b0;
    cyc = 0;
    while (acc < 3 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    check_eq("acc3_reached", (acc >= 3), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_quiet("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();

    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    run_xfer(2, 0, 5, -1);
    run_xfer(9, 2, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
